// File: rtl/logic_unit_pkg.sv
// Shared op-code definitions for the bitwise logic lane; also imported by the ALU decoder.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NAND   = 3'b000;
  localparam op_t OP_AND    = 3'b001;
  localparam op_t OP_OR     = 3'b010;
  localparam op_t OP_NOR    = 3'b011;
  localparam op_t OP_XOR    = 3'b100;
  localparam op_t OP_XNOR   = 3'b101;
  localparam op_t OP_PASS_A = 3'b110;
  localparam op_t OP_NOT_A  = 3'b111;

  localparam int MAX_PIPE_DEPTH = 4;

endpackage

// File: rtl/logic_unit_stage.sv
// One valid/ready register slice. Ready looks through an empty slot so bubbles collapse
// even while the output is stalled.
module logic_unit_stage #(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev_data,
  output logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  input  logic              next_ready
);

  assign ready = !valid || next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= prev_valid;
      if (prev_valid)
        data <= prev_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: 8 ops, PIPE_DEPTH valid/ready stages, zero flag.
// Optional completed-transfer counter enabled by defining LOGIC_UNIT_CNT_EN.
module logic_unit_pipe #(
  parameter int WIDTH      = 32,
  parameter int PIPE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_zero
`ifdef LOGIC_UNIT_CNT_EN
  ,
  output logic [31:0]      out_count
`endif
);

  import logic_unit_pkg::*;

  logic [WIDTH-1:0] result;
  logic             result_zero;

  always_comb begin
    result = '0;
    case (op_t'(in_op))
      OP_NAND:   result = ~(in_a & in_b);
      OP_AND:    result = in_a & in_b;
      OP_OR:     result = in_a | in_b;
      OP_NOR:    result = ~(in_a | in_b);
      OP_XOR:    result = in_a ^ in_b;
      OP_XNOR:   result = ~(in_a ^ in_b);
      OP_PASS_A: result = in_a;
      OP_NOT_A:  result = ~in_a;
      default:   result = '0;
    endcase
  end

  assign result_zero = (result == '0);

  // Index 0 is the input side, index PIPE_DEPTH the output side; each stage links i to i+1.
  logic [PIPE_DEPTH:0] stage_valid;
  logic [PIPE_DEPTH:0] stage_ready;
  logic [WIDTH:0]      stage_data [PIPE_DEPTH+1];

  assign stage_valid[0]          = in_valid;
  assign stage_data[0]           = {result_zero, result};
  assign stage_ready[PIPE_DEPTH] = out_ready;

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    logic_unit_stage #(
      .DATA_W(WIDTH + 1)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .prev_valid (stage_valid[i]),
      .prev_data  (stage_data[i]),
      .ready      (stage_ready[i]),
      .valid      (stage_valid[i+1]),
      .data       (stage_data[i+1]),
      .next_ready (stage_ready[i+1])
    );
  end

  assign in_ready  = !rst && stage_ready[0];
  assign out_valid = stage_valid[PIPE_DEPTH];
  assign out_c     = stage_data[PIPE_DEPTH][WIDTH-1:0];
  assign out_zero  = stage_data[PIPE_DEPTH][WIDTH];

`ifdef LOGIC_UNIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      out_count <= '0;
    else if (out_valid && out_ready && out_count != 32'hFFFF_FFFF)
      out_count <= out_count + 32'd1;
  end
`endif

endmodule
